// File: rtl/nibble_parity_checker_if.sv
// Beat and result handshake bundle for nibble_parity_checker.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid && ready; the producer holds its payload stable while valid && !ready.
interface nibble_parity_checker_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_par;
   logic       res_valid;
   logic       res_ready;
   logic       res_ok;
   logic       res_nib_err;
   logic       res_col_err;

   modport master (
      output in_valid, in_data, in_par, res_ready,
      input  in_ready, res_valid, res_ok, res_nib_err, res_col_err
   );

   modport slave (
      input  in_valid, in_data, in_par, res_ready,
      output in_ready, res_valid, res_ok, res_nib_err, res_col_err
   );
endinterface

// File: rtl/nibble_parity_checker.sv
// Frame checker: FRAME_LEN data nibbles plus one column-parity trailer, with
// per-nibble parity check, pass/fail result handshake and saturating counters.
module nibble_parity_checker #(
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nibble_parity_checker_if.slave bus,
   input  logic                 clr,
   output logic [CNT_W-1:0]     frame_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      ST_DATA   = 2'd0,
      ST_TRAIL  = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);

   state_t     state;
   state_t     state_nxt;
   logic       in_ready_c;
   logic       res_valid_c;
   logic [7:0] beat_cnt;
   logic [3:0] col_acc;
   logic       nib_flag;
   logic       res_ok_q;
   logic       res_nib_q;
   logic       res_col_q;
   logic       in_acc;
   logic       res_acc;
   logic       beat_mis;
   logic       trail_nib;
   logic       trail_col;

   assign in_acc    = bus.in_valid && in_ready_c;
   assign res_acc   = res_valid_c && bus.res_ready;
   assign beat_mis  = bus.in_par ^ (^bus.in_data);
   assign trail_nib = nib_flag | beat_mis;
   assign trail_col = (bus.in_data != col_acc);

   assign bus.in_ready    = in_ready_c;
   assign bus.res_valid   = res_valid_c;
   assign bus.res_ok      = res_ok_q;
   assign bus.res_nib_err = res_nib_q;
   assign bus.res_col_err = res_col_q;
   assign state_dbg       = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_DATA;
      else        state <= state_nxt;
   end

   // in_ready is a function of state only; the case uses in_valid directly
   // to avoid a combinational path back through in_ready_c.
   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      res_valid_c = 1'b0;
      case (state)
         ST_DATA: begin
            in_ready_c = 1'b1;
            if (bus.in_valid && beat_cnt == LAST_BEAT) state_nxt = ST_TRAIL;
         end
         ST_TRAIL: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = ST_RESULT;
         end
         ST_RESULT: begin
            res_valid_c = 1'b1;
            if (bus.res_ready) state_nxt = ST_DATA;
         end
         default: state_nxt = ST_DATA;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= 8'd0;
         col_acc   <= 4'd0;
         nib_flag  <= 1'b0;
         res_ok_q  <= 1'b0;
         res_nib_q <= 1'b0;
         res_col_q <= 1'b0;
      end else begin
         case (state)
            ST_DATA: begin
               if (in_acc) begin
                  col_acc  <= col_acc ^ bus.in_data;
                  nib_flag <= nib_flag | beat_mis;
                  beat_cnt <= beat_cnt + 8'd1;
               end
            end
            ST_TRAIL: begin
               if (in_acc) begin
                  res_nib_q <= trail_nib;
                  res_col_q <= trail_col;
                  res_ok_q  <= ~(trail_nib | trail_col);
               end
            end
            ST_RESULT: begin
               if (res_acc) begin
                  col_acc  <= 4'd0;
                  nib_flag <= 1'b0;
                  beat_cnt <= 8'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // clr takes priority over a coincident result acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else if (clr) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else if (res_acc) begin
         if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
         if (!res_ok_q && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_nibble_parity_checker.sv
// Directed bench for nibble_parity_checker with FRAME_LEN=4, CNT_W=2; results
// are checked by a negedge monitor against a queue of hand-computed outcomes.
module tb_nibble_parity_checker;
   localparam int FRAME_LEN = 4;
   localparam int CNT_W     = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [1:0]       state_dbg;

   nibble_parity_checker_if bus ();

   nibble_parity_checker #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .clr       (clr),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   logic [2:0] exp_q[$];
   int exp_pushed = 0;
   int res_seen = 0;
   int hs_cyc = 0;
   int first_acc_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n && bus.res_valid && bus.res_ready) begin
         logic [2:0] got;
         logic [2:0] exp;
         got = {bus.res_ok, bus.res_nib_err, bus.res_col_err};
         hs_cyc = cyc + 1;
         res_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result actual=%b expected=none", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               failures++;
               $display("FAIL result{ok,nib,col} actual=%b expected=%b (t=%0t)", got, exp, $time);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [3:0] d, input logic p, input int gap, output int acc_cyc);
      bit acc;
      int n;
      bus.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_par   = p;
      n = 0;
      acc = 1'b0;
      acc_cyc = -1;
      do begin
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (acc) acc_cyc = cyc;
      else begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=no_accept expected=accept data=%h", d);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] t,
                             input logic tp, input logic [2:0] exp, input int max_gap);
      int c;
      exp_q.push_back(exp);
      exp_pushed++;
      for (int i = 0; i < FRAME_LEN; i++) begin
         send_beat(d[i*4 +: 4], p[i], $urandom_range(0, max_gap), c);
         if (i == 0) first_acc_cyc = c;
      end
      send_beat(t, tp, $urandom_range(0, max_gap), c);
      check("res_valid_latency", bus.res_valid, 1);
   endtask

   task automatic wait_res;
      int n;
      n = 0;
      while (res_seen < exp_pushed && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (res_seen < exp_pushed) begin
         checks++;
         failures++;
         $display("FAIL result_timeout actual=%0d expected=%0d", res_seen, exp_pushed);
      end
   endtask

   task automatic check_counts(input string name, input int f, input int e);
      check({name, "_frame_cnt"}, frame_cnt, f);
      check({name, "_err_cnt"}, err_cnt, e);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_ok", bus.res_ok, 0);
      check("rst_nib_err", bus.res_nib_err, 0);
      check("rst_col_err", bus.res_col_err, 0);
      check_counts("rst", 0, 0);
      exp_q.delete();
      res_seen = exp_pushed;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int c;
      bus.in_valid  = 1'b0;
      bus.in_data   = 4'h0;
      bus.in_par    = 1'b0;
      bus.res_ready = 1'b1;

      do_reset();

      // clean frame, nibble error, column error
      send_frame(16'h8421, 4'b1111, 4'hF, 1'b0, 3'b100, 0);
      wait_res();
      check_counts("clean", 1, 0);
      send_frame(16'h8421, 4'b1011, 4'hF, 1'b0, 3'b010, 0);
      wait_res();
      check_counts("nib", 2, 1);
      send_frame(16'h8421, 4'b1111, 4'hE, 1'b1, 3'b001, 0);
      wait_res();
      check_counts("col", 3, 2);

      // bubbles plus result backpressure for 5 cycles
      bus.res_ready = 1'b0;
      send_frame(16'h6953, 4'b0000, 4'h9, 1'b0, 3'b100, 3);
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", bus.in_ready, 0);
         check("stall_res_valid", bus.res_valid, 1);
         check("stall_result", {bus.res_ok, bus.res_nib_err, bus.res_col_err}, 3'b100);
         @(posedge clk);
         #1;
      end
      bus.res_ready = 1'b1;
      send_frame(16'h8421, 4'b1111, 4'hF, 1'b0, 3'b100, 0);
      check("beat1_after_handshake", first_acc_cyc, hs_cyc + 1);
      wait_res();
      check_counts("bp", 3, 2);

      // reset in the middle of a frame
      send_beat(4'h1, 1'b1, 0, c);
      send_beat(4'h2, 1'b1, 0, c);
      do_reset();
      send_frame(16'h8421, 4'b1111, 4'hF, 1'b0, 3'b100, 1);
      wait_res();
      check_counts("post_rst", 1, 0);

      // saturation with CNT_W=2, then clr coinciding with a handshake
      do_reset();
      send_frame(16'h8421, 4'b1111, 4'hE, 1'b1, 3'b001, 0);
      wait_res();
      check_counts("sat1", 1, 1);
      send_frame(16'h8421, 4'b1111, 4'hF, 1'b1, 3'b010, 0);
      wait_res();
      check_counts("sat2", 2, 2);
      send_frame(16'h8421, 4'b1110, 4'hF, 1'b0, 3'b010, 0);
      wait_res();
      check_counts("sat3", 3, 3);
      send_frame(16'h8421, 4'b1111, 4'hE, 1'b1, 3'b001, 0);
      wait_res();
      check_counts("sat4", 3, 3);
      send_frame(16'h8421, 4'b0111, 4'h0, 1'b0, 3'b011, 0);
      wait_res();
      check_counts("sat5", 3, 3);

      bus.res_ready = 1'b0;
      send_frame(16'h8421, 4'b1111, 4'hE, 1'b1, 3'b001, 0);
      clr = 1'b1;
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      check_counts("clr_hs", 0, 0);
      check("clr_in_ready", bus.in_ready, 1);
      send_frame(16'h8421, 4'b1111, 4'hF, 1'b0, 3'b100, 2);
      wait_res();
      check_counts("after_clr", 1, 0);

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
